euler_mac_pipeline: RTL
=======================

# euler_mac_pipeline

Parametrised, multi-lane matrix-vector multiply-accumulate engine for the Euler step datapath. It streams a `shape_0 × shape_1` matrix against a vector, `LANES` elements per beat. Each row is reduced to one signed fixed-point result and returned over a valid/ready output with its row index. It adds lane parallelism, fixed-point scaling, back-pressure, zero-dimension handling and selectable overflow policy to the existing fetch/mul/acc pipeline.

## Interface
- `DATA_SIZE`, 16: signed two's-complement sample width
- `FRAC_BITS`, 8: fractional bits (Q format) of all data
- `MAX_DIM`, 6: width of shape and row-index fields
- `LANES`, 2: elements multiplied per beat (≥1)
- `clk` in 1: clock, all state on rising edge
- `rst` in 1: asynchronous, active-low reset
- `clear` in 1: synchronous flush to IDLE; clears `overflow`
- `start` in 1: job start pulse, honoured only in IDLE
- `shape_0` in MAX_DIM: row count, latched on `start`
- `shape_1` in MAX_DIM: column count, latched on `start`
- `in_valid` in 1: beat valid
- `in_ready` out 1: beat accepted when `in_valid & in_ready`
- `mat_data` in LANES*DATA_SIZE: matrix elements, lane 0 in LSBs
- `vec_data` in LANES*DATA_SIZE: matching vector elements
- `out_valid` out 1: row result valid
- `out_ready` in 1: consumer accepts result
- `out_acc` out DATA_SIZE: row result
- `out_row` out MAX_DIM: row index of `out_acc`
- `busy` out 1: state ≠ IDLE
- `done` out 1: one-cycle pulse, job complete
- `overflow` out 1: sticky overflow flag

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE→RUN on `start` with both shapes nonzero. `start` also clears `overflow`. A zero shape pulses `done` next cycle and stays in IDLE.
- RUN: beats per row = ceil(`shape_1`/`LANES`). On the last beat of a row, lanes with column index ≥ `shape_1` are forced to zero product.
- RUN→DRAIN after the last beat of row `shape_0`-1 is accepted. DRAIN→IDLE on the output handshake of the final row; `done` pulses that cycle+1.
- Stage M: per-lane full-precision product, arithmetic right shift by `FRAC_BITS`, then reduced to DATA_SIZE per the overflow policy.
- Stage T: adder tree sums lanes at DATA_SIZE+clog2(LANES) width.
- Stage A: row accumulator. First beat of a row loads instead of adding. The final beat writes the reduced result into the output register.
- Overflow: `overflow` sets on any product, tree sum or accumulator result outside the DATA_SIZE signed range. It clears only on `start`, `clear` or reset.
- `clear` has priority over `start`. It empties all stages, drops `out_valid` and returns to IDLE without a `done` pulse.

## Timing
- Global stall `hold = out_valid & ~out_ready` freezes every stage; `in_ready = (state==RUN) & ~hold`.
- Latency: last beat of a row accepted at cycle t → `out_valid` at t+3, assuming no stall.
- Throughput: one beat per cycle.
- `out_acc`/`out_row` are stable while `out_valid & ~out_ready`.
- Result accepted at the same edge a new result arrives: the output register reloads, with no bubble.
- `in_valid` low inserts bubbles; partial row sums are preserved.
- Reset values: `in_ready` 0, `out_valid` 0, `out_acc` 0, `out_row` 0, `busy` 0, `done` 0, `overflow` 0; FSM in IDLE.
- Reset or `clear` mid-job discards all partial sums. `start` during RUN/DRAIN is ignored.

## Configuration
- `EULER_SATURATE_EN` defined: out-of-range values clamp to 2^(DATA_SIZE-1)-1 or -2^(DATA_SIZE-1).
- Not defined: out-of-range values wrap (two's-complement truncation).
- `overflow` behaves identically in both builds.

## Structure
- `euler_pkg` holds:
  - FSM state enum;
  - `SAT_MAX`/`SAT_MIN` constants;
  - the `reduce_to_data` function, which does the saturate/wrap under the macro.
- Sub-module `euler_mac_lane`: one multiply-shift-reduce lane with overflow out, instantiated `LANES` times.

## Test plan
- Q8.8, LANES=2, shape 1×2, mat {1.5, 2.0} (0x0180, 0x0200), vec {2.0, 0.5} → `out_acc`=0x0400 (4.0), `out_row`=0, `done` pulse.
- shape 3×3, LANES=2, identity matrix, vec {1,2,3} → rows 0,1,2 output 0x0100, 0x0200, 0x0300; odd-column masking verified.
- `out_ready` held low 5 cycles at row 0 output → `in_ready` low, `out_acc` stable, no lost rows; full job completes.
- Products 0x7F00×0x0200 → `overflow`=1. With the macro, `out_acc`=0x7FFF; without it, the wrapped value 0xFE00.
- `shape_0`=0 `start` → `done` next cycle, `out_valid` never asserted, `busy` stays 0.
- `rst` low mid-row, and separately `clear` mid-row → all outputs at reset values; a fresh 1×2 job gives the correct result.

Source files
------------

// File: rtl/euler_pkg.sv
// Shared types and helpers for the Euler MAC pipeline.
// Build option: EULER_SATURATE_EN selects saturating reduction
// (clamp to the signed DATA_SIZE range); without it values wrap.
package euler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Clamp limits for the default 16-bit sample width; the helpers below
    // derive the same limits for any width up to 32 bits.
    localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAT_MIN = 16'sh8000;

    // True when v fits the signed w-bit range.
    function automatic logic in_data_range(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return (v <= hi) && (v >= lo);
    endfunction

    // Brings v into the signed w-bit range; caller keeps the low w bits.
    function automatic logic signed [63:0] reduce_to_data(input logic signed [63:0] v, input int w);
`ifdef EULER_SATURATE_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
`else
        return (v <<< (64 - w)) >>> (64 - w);
`endif
    endfunction

endpackage

// File: rtl/euler_mac_lane.sv
// One multiply lane: full-precision signed product, rescale by FRAC_BITS,
// reduce to DATA_SIZE. Masked lanes yield zero and never flag overflow.
module euler_mac_lane
    import euler_pkg::*;
#(
    parameter int DATA_SIZE = 16,
    parameter int FRAC_BITS = 8
) (
    input  logic signed [DATA_SIZE-1:0] a_i,
    input  logic signed [DATA_SIZE-1:0] b_i,
    input  logic                        mask_i,
    output logic [DATA_SIZE-1:0]        prod_o,
    output logic                        ovf_o
);

    logic signed [2*DATA_SIZE-1:0] full;
    logic signed [63:0]            scaled;

    // Product, Q-format rescale and range reduction
    always_comb begin
        full   = (2*DATA_SIZE)'(a_i) * (2*DATA_SIZE)'(b_i);
        scaled = 64'(full) >>> FRAC_BITS;
        prod_o = mask_i ? '0 : DATA_SIZE'(reduce_to_data(scaled, DATA_SIZE));
        ovf_o  = !mask_i && !in_data_range(scaled, DATA_SIZE);
    end

endmodule

// File: rtl/euler_mac_pipeline.sv
// Multi-lane matrix-vector MAC: fetch -> M (lane products) -> T (adder
// tree) -> A (row accumulator / output register). One global stall while
// a result waits on out_ready. Overflow policy follows EULER_SATURATE_EN.
module euler_mac_pipeline
    import euler_pkg::*;
#(
    parameter int DATA_SIZE = 16,
    parameter int FRAC_BITS = 8,
    parameter int MAX_DIM   = 6,
    parameter int LANES     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         start,
    input  logic [MAX_DIM-1:0]           shape_0,
    input  logic [MAX_DIM-1:0]           shape_1,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*DATA_SIZE-1:0]   mat_data,
    input  logic [LANES*DATA_SIZE-1:0]   vec_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_SIZE-1:0]         out_acc,
    output logic [MAX_DIM-1:0]           out_row,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow
);

    localparam int TW = DATA_SIZE + $clog2(LANES);
    localparam int CW = MAX_DIM + $clog2(LANES) + 1;

    state_e state_q, state_d;
    logic [MAX_DIM-1:0] shp0_q, shp0_d, shp1_q, shp1_d, row_q, row_d;
    logic [CW-1:0]      col_q, col_d;
    logic               done_q, done_d, ovf_q, ovf_d;

    logic [LANES-1:0][DATA_SIZE-1:0] mat_v, vec_v, lane_prod, m_prod_q;
    logic [LANES-1:0]                lane_mask, lane_ovf;

    // vld_pipe_q[0]: stage M holds a beat, [1]: stage T holds a beat
    logic [1:0]               vld_pipe_q;
    logic                     m_first_q, m_last_q, t_first_q, t_last_q;
    logic [MAX_DIM-1:0]       m_row_q, t_row_q, out_row_q;
    logic signed [DATA_SIZE-1:0] t_sum_q, acc_q, acc_nxt, tree_red;
    logic signed [TW-1:0]        tree_sum;
    logic signed [DATA_SIZE:0]   acc_sum;
    logic                     tree_ovf, acc_ovf;
    logic                     out_valid_q;
    logic [DATA_SIZE-1:0]     out_acc_q;

    logic hold, adv, beat_fire, out_fire, last_beat, last_row;

    assign mat_v     = mat_data;
    assign vec_v     = vec_data;
    assign hold      = out_valid_q & ~out_ready;
    assign adv       = ~hold;
    assign in_ready  = (state_q == ST_RUN) & ~hold;
    assign beat_fire = in_valid & in_ready;
    assign out_fire  = out_valid_q & out_ready;
    assign last_beat = (col_q + CW'(LANES)) >= CW'(shp1_q);
    assign last_row  = (row_q == shp0_q - MAX_DIM'(1));

    // Lanes past the row end on the final beat contribute zero
    always_comb begin
        lane_mask = '0;
        for (int l = 0; l < LANES; l++)
            lane_mask[l] = (col_q + CW'(l)) >= CW'(shp1_q);
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        euler_mac_lane #(
            .DATA_SIZE(DATA_SIZE),
            .FRAC_BITS(FRAC_BITS)
        ) u_lane (
            .a_i    (mat_v[g]),
            .b_i    (vec_v[g]),
            .mask_i (lane_mask[g]),
            .prod_o (lane_prod[g]),
            .ovf_o  (lane_ovf[g])
        );
    end

    // Adder tree over the registered lane products
    always_comb begin
        tree_sum = '0;
        for (int l = 0; l < LANES; l++)
            tree_sum = tree_sum + TW'(signed'(m_prod_q[l]));
        tree_ovf = !in_data_range(64'(tree_sum), DATA_SIZE);
        tree_red = DATA_SIZE'(reduce_to_data(64'(tree_sum), DATA_SIZE));
    end

    // Row accumulation: first beat of a row loads, later beats add
    always_comb begin
        acc_sum = (DATA_SIZE+1)'(acc_q) + (DATA_SIZE+1)'(t_sum_q);
        if (t_first_q) begin
            acc_nxt = t_sum_q;
            acc_ovf = 1'b0;
        end else begin
            acc_nxt = DATA_SIZE'(reduce_to_data(64'(acc_sum), DATA_SIZE));
            acc_ovf = !in_data_range(64'(acc_sum), DATA_SIZE);
        end
    end

    // FSM next state, beat/row counters, done pulse and sticky overflow
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        shp0_d  = shp0_q;
        shp1_d  = shp1_q;
        col_d   = col_q;
        row_d   = row_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: if (start) begin
                shp0_d = shape_0;
                shp1_d = shape_1;
                col_d  = '0;
                row_d  = '0;
                ovf_d  = 1'b0;
                if (shape_0 == '0 || shape_1 == '0) done_d  = 1'b1;
                else                                state_d = ST_RUN;
            end
            ST_RUN: if (beat_fire) begin
                if (last_beat) begin
                    col_d = '0;
                    row_d = row_q + MAX_DIM'(1);
                    if (last_row) state_d = ST_DRAIN;
                end else begin
                    col_d = col_q + CW'(LANES);
                end
            end
            ST_DRAIN: if (out_fire && out_row_q == shp0_q - MAX_DIM'(1)) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        if ((beat_fire && |lane_ovf) ||
            (adv && vld_pipe_q[0] && tree_ovf) ||
            (adv && vld_pipe_q[1] && acc_ovf))
            ovf_d = 1'b1;
        if (clear) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            ovf_d   = 1'b0;
            col_d   = '0;
            row_d   = '0;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            shp0_q  <= '0;
            shp1_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            shp0_q  <= shp0_d;
            shp1_q  <= shp1_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // Stages M and T, frozen together while the output is stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe_q <= '0;
            m_prod_q   <= '0;
            m_first_q  <= 1'b0;
            m_last_q   <= 1'b0;
            m_row_q    <= '0;
            t_sum_q    <= '0;
            t_first_q  <= 1'b0;
            t_last_q   <= 1'b0;
            t_row_q    <= '0;
        end else if (clear) begin
            vld_pipe_q <= '0;
        end else if (adv) begin
            vld_pipe_q <= {vld_pipe_q[0], beat_fire};
            m_prod_q   <= lane_prod;
            m_first_q  <= (col_q == '0);
            m_last_q   <= last_beat;
            m_row_q    <= row_q;
            t_sum_q    <= tree_red;
            t_first_q  <= m_first_q;
            t_last_q   <= m_last_q;
            t_row_q    <= m_row_q;
        end
    end

    // Stage A: accumulator and output register (reloads on same-edge accept)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_row_q   <= '0;
        end else if (clear) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_row_q   <= '0;
        end else if (adv) begin
            if (vld_pipe_q[1]) acc_q <= acc_nxt;
            if (vld_pipe_q[1] && t_last_q) begin
                out_valid_q <= 1'b1;
                out_acc_q   <= acc_nxt;
                out_row_q   <= t_row_q;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_row   = out_row_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign overflow  = ovf_q;

endmodule
